// File: rtl/amp_pwr_seq.sv
// Class-D amp power sequencer with soft-mute gain ramps and debounced fault shutdown; 1-cycle sample latency, no backpressure.
// Build with AMP_AUTO_RETRY_EN defined to restart automatically out of FAULT once the fault line stays high.
module amp_pwr_seq #(
    parameter int STARTUP_CYC = 250000,
    parameter int RETRY_CYC   = 2500000,
    parameter int FLT_FILT    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vld,
    input  logic [15:0] lft_in,
    input  logic [15:0] rght_in,
    input  logic        mute,
    input  logic        Flt_n,
    output logic [15:0] lft_out,
    output logic [15:0] rght_out,
    output logic        vld_out,
    output logic        sht_dwn,
    output logic [3:0]  fault_cnt
);

    localparam int SU_W = (STARTUP_CYC > 1) ? $clog2(STARTUP_CYC) : 1;
    localparam int RT_W = (RETRY_CYC > 1) ? $clog2(RETRY_CYC) : 1;
    localparam int FL_W = $clog2(FLT_FILT + 1);
    localparam logic [8:0] G_MAX = 9'd256;

    typedef enum logic [2:0] {
        SHDN,
        RAMP_UP,
        RUN,
        RAMP_DN,
        MUTED,
        FAULT
    } state_t;

    state_t            state_q, state_d;
    logic [8:0]        g_q, g_d;
    logic [SU_W-1:0]   su_q, su_d;
    logic [FL_W-1:0]   filt_q, filt_d;
    logic [3:0]        fcnt_q, fcnt_d;
    logic              s1_q, s2_q;
    logic [15:0]       lft_q, lft_d;
    logic [15:0]       rght_q, rght_d;
    logic              vld_out_q;
    logic              sht_dwn_q, sht_dwn_d;

    logic              flt_low;
    logic              qual;
    logic              active;
    logic [8:0]        g_up, g_dn, g_eff;

`ifdef AMP_AUTO_RETRY_EN
    logic [RT_W-1:0]   rt_q, rt_d;
`endif

    function automatic logic [15:0] scale(input logic [15:0] s, input logic [8:0] g);
        logic signed [24:0] p;
        p = 25'($signed(s)) * 25'($signed({1'b0, g}));
        return 16'(p >>> 8);
    endfunction

    // The fault qualifies on the very sample that completes the FLT_FILT-long low run.
    assign flt_low = ~s2_q;
    assign qual    = flt_low && (filt_q >= FL_W'(FLT_FILT - 1));
    assign active  = (state_q == RAMP_UP) || (state_q == RUN) ||
                     (state_q == RAMP_DN) || (state_q == MUTED);
    assign g_up    = (vld && g_q != G_MAX) ? g_q + 9'd1 : g_q;
    assign g_dn    = (vld && g_q != 9'd0)  ? g_q - 9'd1 : g_q;
    assign g_eff   = qual ? 9'd0 : g_q;

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        su_d    = su_q;
        fcnt_d  = fcnt_q;
`ifdef AMP_AUTO_RETRY_EN
        rt_d    = rt_q;
`endif
        if (!flt_low) begin
            filt_d = '0;
        end else if (filt_q == FL_W'(FLT_FILT)) begin
            filt_d = filt_q;
        end else begin
            filt_d = filt_q + FL_W'(1);
        end

        case (state_q)
            SHDN: begin
                g_d = '0;
                if (qual) begin
                    su_d = '0;
                end else if (su_q == SU_W'(STARTUP_CYC - 1)) begin
                    su_d    = '0;
                    state_d = RAMP_UP;
                end else begin
                    su_d = su_q + SU_W'(1);
                end
            end
            RAMP_UP: begin
                g_d = g_up;
                // A step that lands on a limit wins; the mute direction is re-examined next cycle.
                if (g_up == G_MAX) begin
                    state_d = RUN;
                end else if (mute) begin
                    state_d = (g_up == 9'd0) ? MUTED : RAMP_DN;
                end
            end
            RUN: begin
                g_d = G_MAX;
                if (mute) begin
                    state_d = RAMP_DN;
                end
            end
            RAMP_DN: begin
                g_d = g_dn;
                if (g_dn == 9'd0) begin
                    state_d = MUTED;
                end else if (!mute) begin
                    state_d = (g_dn == G_MAX) ? RUN : RAMP_UP;
                end
            end
            MUTED: begin
                g_d = '0;
                if (!mute) begin
                    state_d = RAMP_UP;
                end
            end
            FAULT: begin
                g_d = '0;
`ifdef AMP_AUTO_RETRY_EN
                if (flt_low) begin
                    rt_d = '0;
                end else if (rt_q == RT_W'(RETRY_CYC - 1)) begin
                    rt_d    = '0;
                    su_d    = '0;
                    state_d = SHDN;
                end else begin
                    rt_d = rt_q + RT_W'(1);
                end
`endif
            end
            default: begin
                g_d     = '0;
                su_d    = '0;
                state_d = SHDN;
            end
        endcase

        if (qual && active) begin
            state_d = FAULT;
            g_d     = '0;
            fcnt_d  = (fcnt_q == 4'd15) ? fcnt_q : fcnt_q + 4'd1;
`ifdef AMP_AUTO_RETRY_EN
            rt_d    = '0;
`endif
        end

        sht_dwn_d = (state_d == SHDN) || (state_d == FAULT);
        lft_d     = vld ? scale(lft_in, g_eff)  : lft_q;
        rght_d    = vld ? scale(rght_in, g_eff) : rght_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= SHDN;
            g_q       <= '0;
            su_q      <= '0;
            filt_q    <= '0;
            fcnt_q    <= '0;
            s1_q      <= 1'b1;
            s2_q      <= 1'b1;
            lft_q     <= '0;
            rght_q    <= '0;
            vld_out_q <= 1'b0;
            sht_dwn_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            g_q       <= g_d;
            su_q      <= su_d;
            filt_q    <= filt_d;
            fcnt_q    <= fcnt_d;
            s1_q      <= Flt_n;
            s2_q      <= s1_q;
            lft_q     <= lft_d;
            rght_q    <= rght_d;
            vld_out_q <= vld;
            sht_dwn_q <= sht_dwn_d;
        end
    end

`ifdef AMP_AUTO_RETRY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            rt_q <= '0;
        end else begin
            rt_q <= rt_d;
        end
    end
`endif

    assign lft_out   = lft_q;
    assign rght_out  = rght_q;
    assign vld_out   = vld_out_q;
    assign sht_dwn   = sht_dwn_q;
    assign fault_cnt = fcnt_q;

endmodule
